trng_bit_packer: RTL and testbench
==================================

// Module: trng_bit_packer
// PURPOSE
//   Downstream of the TRNG health test. Consumes the raw serial bit stream, optionally
//   applies von Neumann debiasing, and packs bits MSB-first into WORD_W-bit words.
//   A word is discarded if healthtest_err was high in any cycle during its accumulation.
//   Accepted words enter a small FWFT FIFO with a valid/ready interface to the TRNG register/DMA side.
// PARAMETERS
//   WORD_W      32  output word width; bits per packed word
//   FIFO_DEPTH  4   word FIFO entries; power of two, >=2
//   DROP_W      16  width of the saturating drop counter
// PORTS
//   clk            in   1          system clock
//   rstn           in   1          synchronous active-low reset
//   digi_data_out  in   1          raw entropy bit
//   digi_data_vld  in   1          qualifies digi_data_out, one bit per cycle
//   healthtest_err in   1          health-test failure level from the health test stage
//   pack_en        in   1          enable; 0 = flush partial word and ignore bits
//   vn_en          in   1          1 = von Neumann debias, 0 = pass bits through
//   word_data      out  WORD_W     FIFO head; forced to 0 when word_vld=0
//   word_vld       out  1          FIFO non-empty
//   word_rdy       in   1          consumer accepts head when word_vld & word_rdy
//   fifo_level     out  clog2(D)+1 current FIFO occupancy, 0..FIFO_DEPTH
//   word_drop      out  1          1-cycle pulse per discarded completed word
//   drop_cnt       out  DROP_W     discarded-word count, saturates at all-ones
// BEHAVIOUR
//   - Reset (rstn=0 at posedge clk): FSM->OFF, shift reg/bit count/taint/VN half cleared, FIFO emptied;
//     word_vld=0, word_data=0, fifo_level=0, word_drop=0, drop_cnt=0. Reset mid-word discards everything.
//   - FSM: OFF (pack_en=0) -> COLLECT when pack_en=1. COLLECT -> OFF when pack_en=0; on that edge the
//     partial word, taint, bit count and VN half are cleared; FIFO content is retained and still drainable.
//   - Bit acceptance (COLLECT, digi_data_vld=1):
//     vn_en=0: every valid bit accepted.
//     vn_en=1: alternate valid bits form pairs (first latched, vn_half=1). On the second bit:
//       differ -> accept the first bit; equal -> discard both. vn_half then clears.
//     Toggling vn_en mid-word takes effect next bit and clears vn_half.
//   - Packing: accepted bit shifts into LSB: sreg <= {sreg[WORD_W-2:0], bit}; first bit ends in MSB.
//     bit count 0..WORD_W-1; accepting with count=WORD_W-1 completes the word, count wraps to 0.
//   - Taint: set any COLLECT cycle with healthtest_err=1 (valid or not). On completion the word is
//     dropped if taint (incl. err in the completing cycle) is set; taint then clears, re-armed next cycle.
//   - Push: completed, untainted word pushed if FIFO not full OR a pop occurs in the same cycle;
//     otherwise dropped. Any drop: word_drop=1 next cycle, drop_cnt+1 (saturating).
//   - Latency: completing bit at edge N -> word_vld=1 and word_data valid after edge N+1 (FIFO empty).
//   - Pop: word_vld & word_rdy at edge removes head; new head visible same edge. Simultaneous
//     push+pop: level unchanged. Pop on empty ignored. Pointers wrap modulo FIFO_DEPTH.
// STRUCTURE
//   - Shared package trng_pkg: WORD_W/FIFO_DEPTH defaults, packer FSM encoding (OFF, COLLECT).
//   - Sub-module trng_word_fifo: sync FWFT FIFO (wr_en, wr_data, rd_en, rd_data, empty, full, level),
//     same clk/rstn; packer FSM, VN logic, shift reg, taint and drop counter stay in this module.
// TESTING
//   1. vn_en=0, err=0, 32 valid bits 0xA5A5A5A5 MSB-first -> next cycle word_vld=1,
//      word_data=0xA5A5A5A5, fifo_level=1.
//   2. vn_en=1, 32 pairs "01","10" alternating plus "00"/"11" pairs interleaved -> one word
//      0x55555555; discarded pairs add no bits.
//   3. err=1 for one cycle during bit 10 of word 1 -> word 1 dropped, word_drop one cycle,
//      drop_cnt=1; word 2 clean -> pushed.
//   4. word_rdy=0, push 5 clean words -> fifo_level=4, 5th dropped, drop_cnt=1; word_rdy=1
//      -> words 1..4 drained in order, level 4->0; push+pop while full keeps level=4, no drop.
//   5. pack_en=0 after 20 bits, then 1, then 32 bits 0xDEADBEEF -> only 0xDEADBEEF emitted.
//   6. rstn=0 one cycle with 2 FIFO words and 17-bit partial -> word_vld=0, fifo_level=0,
//      drop_cnt=0; next 32 bits form a fresh word.

Source files
------------

// File: rtl/trng_pkg.sv
// Shared definitions for the TRNG output path: default geometry and the packer FSM encoding.
package trng_pkg;

    localparam int WORD_W_DEF     = 32;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int DROP_W_DEF     = 16;

    typedef enum logic {
        ST_OFF     = 1'b0,
        ST_COLLECT = 1'b1
    } pack_state_e;

endpackage

// File: rtl/trng_word_fifo.sv
// Small synchronous first-word-fall-through FIFO holding packed entropy words.
module trng_word_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     wr_en,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]    count_q, count_d;
    logic             rd_ok, wr_ok;

    assign empty = (count_q == '0);
    assign full  = (count_q == LW'(DEPTH));
    assign level = count_q;

    // A write into a full FIFO is legal only when the head leaves in the same cycle.
    assign rd_ok = rd_en & ~empty;
    assign wr_ok = wr_en & (~full | rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (rd_ok) rd_ptr_d = rd_ptr_q + 1'b1;
        case ({wr_ok, rd_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];

endmodule

// File: rtl/trng_bit_packer.sv
// Packs the health-tested TRNG bit stream (optionally von Neumann debiased) into words,
// discards words tainted by health-test errors, and queues the rest for the consumer.
module trng_bit_packer
    import trng_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int DROP_W     = DROP_W_DEF
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          digi_data_out,
    input  logic                          digi_data_vld,
    input  logic                          healthtest_err,
    input  logic                          pack_en,
    input  logic                          vn_en,
    output logic [WORD_W-1:0]             word_data,
    output logic                          word_vld,
    input  logic                          word_rdy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          word_drop,
    output logic [DROP_W-1:0]             drop_cnt
);

    localparam int CW = $clog2(WORD_W);

    pack_state_e       state_q, state_d;
    logic [WORD_W-1:0] sreg_q, sreg_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              taint_q, taint_d;
    logic              vn_half_q, vn_half_d;
    logic              vn_first_q, vn_first_d;
    logic              vn_en_q;
    logic              stg_vld_q, stg_vld_d;
    logic [WORD_W-1:0] stg_data_q, stg_data_d;
    logic              stg_taint_q, stg_taint_d;
    logic              word_drop_q, word_drop_d;
    logic [DROP_W-1:0] drop_cnt_q, drop_cnt_d;

    logic              collecting, half_eff, bit_acc, acc_bit;
    logic              pop, push_ok, drop;
    logic              fifo_empty, fifo_full;
    logic [WORD_W-1:0] fifo_head;

    always_comb begin
        state_d     = pack_en ? ST_COLLECT : ST_OFF;
        sreg_d      = sreg_q;
        cnt_d       = cnt_q;
        taint_d     = taint_q;
        vn_half_d   = vn_half_q;
        vn_first_d  = vn_first_q;
        stg_vld_d   = 1'b0;
        stg_data_d  = stg_data_q;
        stg_taint_d = 1'b0;
        bit_acc     = 1'b0;
        acc_bit     = 1'b0;
        collecting  = (state_q == ST_COLLECT) && pack_en;
        // A change of debias mode abandons any half-formed pair.
        half_eff    = vn_half_q && (vn_en == vn_en_q);

        if (collecting) begin
            vn_half_d = half_eff;
            taint_d   = taint_q | healthtest_err;
            if (digi_data_vld) begin
                if (!vn_en) begin
                    bit_acc = 1'b1;
                    acc_bit = digi_data_out;
                end else if (!half_eff) begin
                    vn_first_d = digi_data_out;
                    vn_half_d  = 1'b1;
                end else begin
                    vn_half_d = 1'b0;
                    if (vn_first_q != digi_data_out) begin
                        bit_acc = 1'b1;
                        acc_bit = vn_first_q;
                    end
                end
            end
            if (bit_acc) begin
                sreg_d = {sreg_q[WORD_W-2:0], acc_bit};
                if (cnt_q == CW'(WORD_W - 1)) begin
                    cnt_d       = '0;
                    stg_vld_d   = 1'b1;
                    stg_data_d  = {sreg_q[WORD_W-2:0], acc_bit};
                    stg_taint_d = taint_q | healthtest_err;
                    taint_d     = 1'b0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        end else begin
            sreg_d    = '0;
            cnt_d     = '0;
            taint_d   = 1'b0;
            vn_half_d = 1'b0;
        end
    end

    // Completed words are staged one cycle before the push/drop decision.
    assign pop     = word_vld & word_rdy;
    assign push_ok = stg_vld_q & ~stg_taint_q & (~fifo_full | pop);
    assign drop    = stg_vld_q & ~push_ok;

    always_comb begin
        word_drop_d = drop;
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) drop_cnt_d = drop_cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q     <= ST_OFF;
            sreg_q      <= '0;
            cnt_q       <= '0;
            taint_q     <= 1'b0;
            vn_half_q   <= 1'b0;
            vn_first_q  <= 1'b0;
            vn_en_q     <= 1'b0;
            stg_vld_q   <= 1'b0;
            stg_data_q  <= '0;
            stg_taint_q <= 1'b0;
            word_drop_q <= 1'b0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sreg_q      <= sreg_d;
            cnt_q       <= cnt_d;
            taint_q     <= taint_d;
            vn_half_q   <= vn_half_d;
            vn_first_q  <= vn_first_d;
            vn_en_q     <= vn_en;
            stg_vld_q   <= stg_vld_d;
            stg_data_q  <= stg_data_d;
            stg_taint_q <= stg_taint_d;
            word_drop_q <= word_drop_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    trng_word_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .wr_en   (push_ok),
        .wr_data (stg_data_q),
        .rd_en   (word_rdy),
        .rd_data (fifo_head),
        .empty   (fifo_empty),
        .full    (fifo_full),
        .level   (fifo_level)
    );

    assign word_vld  = ~fifo_empty;
    assign word_data = word_vld ? fifo_head : '0;
    assign word_drop = word_drop_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_trng_bit_packer.sv
// Randomised and directed checking of trng_bit_packer against a queue-based reference model.
module tb_trng_bit_packer;

    localparam int W  = 32;
    localparam int D  = 4;
    localparam int DW = 4;

    logic          clk;
    logic          rstn;
    logic          digi_data_out;
    logic          digi_data_vld;
    logic          healthtest_err;
    logic          pack_en;
    logic          vn_en;
    logic [W-1:0]  word_data;
    logic          word_vld;
    logic          word_rdy;
    logic [2:0]    fifo_level;
    logic          word_drop;
    logic [DW-1:0] drop_cnt;

    trng_bit_packer #(
        .WORD_W     (W),
        .FIFO_DEPTH (D),
        .DROP_W     (DW)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .digi_data_out  (digi_data_out),
        .digi_data_vld  (digi_data_vld),
        .healthtest_err (healthtest_err),
        .pack_en        (pack_en),
        .vn_en          (vn_en),
        .word_data      (word_data),
        .word_vld       (word_vld),
        .word_rdy       (word_rdy),
        .fifo_level     (fifo_level),
        .word_drop      (word_drop),
        .drop_cnt       (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, act, exp);
        end
    endtask

    // Reference model: accepted bits collect in a queue; a full queue becomes a word.
    logic         m_on, m_taint, m_vnhalf, m_vnfirst, m_vnprev;
    bit           m_bits[$];
    logic         m_stg_vld, m_stg_taint;
    logic [W-1:0] m_stg_data;
    logic [W-1:0] m_fifo[$];
    logic         m_drop;
    int           m_dropcnt;

    task automatic model_reset();
        m_on = 0; m_taint = 0; m_vnhalf = 0; m_vnfirst = 0; m_vnprev = 0;
        m_bits.delete();
        m_stg_vld = 0; m_stg_taint = 0; m_stg_data = '0;
        m_fifo.delete();
        m_drop = 0; m_dropcnt = 0;
    endtask

    task automatic model_step();
        logic         have, b, half, on, n_vld, n_taint, dropped;
        logic [W-1:0] w;
        if (!rstn) begin
            model_reset();
            return;
        end
        dropped = 0;
        if (m_fifo.size() > 0 && word_rdy) begin
            $display("POP  word=%08h", m_fifo[0]);
            void'(m_fifo.pop_front());
        end
        if (m_stg_vld) begin
            if (m_stg_taint || m_fifo.size() >= D) dropped = 1;
            else m_fifo.push_back(m_stg_data);
        end
        m_drop = dropped;
        if (dropped) begin
            $display("DROP word=%08h", m_stg_data);
            if (m_dropcnt < (1 << DW) - 1) m_dropcnt++;
        end
        n_vld = 0; n_taint = 0; w = '0;
        on = m_on && pack_en;
        if (on) begin
            have = 0; b = 0;
            half = m_vnhalf && (vn_en == m_vnprev);
            if (digi_data_vld) begin
                if (!vn_en) begin
                    have = 1; b = digi_data_out;
                end else if (!half) begin
                    m_vnfirst = digi_data_out; half = 1;
                end else begin
                    half = 0;
                    if (m_vnfirst != digi_data_out) begin
                        have = 1; b = m_vnfirst;
                    end
                end
            end
            m_vnhalf = half;
            m_taint = m_taint | healthtest_err;
            if (have) m_bits.push_back(b);
            if (m_bits.size() == W) begin
                foreach (m_bits[k]) w = {w[W-2:0], m_bits[k]};
                n_vld = 1; n_taint = m_taint;
                m_bits.delete();
                m_taint = 0;
            end
        end else begin
            m_bits.delete();
            m_taint = 0;
            m_vnhalf = 0;
        end
        m_stg_vld = n_vld;
        m_stg_taint = n_taint;
        if (n_vld) m_stg_data = w;
        m_vnprev = vn_en;
        m_on = pack_en;
    endtask

    task automatic compare_all();
        chk("word_vld", word_vld, m_fifo.size() > 0);
        chk("word_data", word_data, (m_fifo.size() > 0) ? m_fifo[0] : '0);
        chk("fifo_level", fifo_level, m_fifo.size());
        chk("word_drop", word_drop, m_drop);
        chk("drop_cnt", drop_cnt, m_dropcnt);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        digi_data_vld = 0; healthtest_err = 0;
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic send_bit(input logic b, input logic err);
        digi_data_vld = 1; digi_data_out = b; healthtest_err = err;
        tick();
        digi_data_vld = 0; healthtest_err = 0;
    endtask

    task automatic send_word_err(input logic [W-1:0] w, input int err_at);
        for (int i = 0; i < W; i++) send_bit(w[W-1-i], (i == err_at) || (err_at == 99));
    endtask

    task automatic send_word(input logic [W-1:0] w);
        send_word_err(w, -1);
    endtask

    task automatic send_vn_word(input logic [W-1:0] w);
        logic b;
        for (int i = 0; i < W; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 1'($urandom_range(0, 1));
                send_bit(b, 0);
                send_bit(b, 0);
            end
            send_bit(w[W-1-i], 0);
            send_bit(~w[W-1-i], 0);
        end
    endtask

    task automatic drain();
        word_rdy = 1;
        idle(D + 1);
        word_rdy = 0;
    endtask

    initial begin
        logic [W-1:0] rw;
        model_reset();
        rstn = 0; digi_data_out = 0; digi_data_vld = 0; healthtest_err = 0;
        pack_en = 0; vn_en = 0; word_rdy = 0;
        tick(); tick();
        chk("rst_vld", word_vld, 1'b0);
        chk("rst_cnt", drop_cnt, '0);
        rstn = 1; pack_en = 1;
        idle(1);

        // plain packing
        send_word(32'hA5A5A5A5);
        idle(1);
        chk("t1_data", word_data, 32'hA5A5A5A5);
        chk("t1_level", fifo_level, 3'd1);
        drain();

        // von Neumann debiasing with discarded pairs
        vn_en = 1;
        idle(1);
        send_vn_word(32'h55555555);
        idle(1);
        chk("t2_data", word_data, 32'h55555555);
        drain();
        vn_en = 0;
        idle(1);

        // taint during bit 10
        send_word_err(32'h12345678, 10);
        idle(1);
        chk("t3_drop", word_drop, 1'b1);
        chk("t3_cnt", drop_cnt, 4'd1);
        send_word(32'hCAFEF00D);
        idle(1);
        chk("t3_data", word_data, 32'hCAFEF00D);
        drain();

        // overflow, then push+pop while full
        for (int i = 0; i < 5; i++) send_word(32'h1000_0000 + i);
        idle(1);
        chk("t4_level", fifo_level, 3'd4);
        chk("t4_cnt", drop_cnt, 4'd2);
        send_word(32'h2000_0006);
        word_rdy = 1;
        idle(1);
        word_rdy = 0;
        chk("t4_full_level", fifo_level, 3'd4);
        chk("t4_full_cnt", drop_cnt, 4'd2);
        chk("t4_head", word_data, 32'h1000_0001);
        drain();

        // partial word flushed by pack_en=0
        for (int i = 0; i < 20; i++) send_bit(1'($urandom_range(0, 1)), 0);
        pack_en = 0;
        idle(2);
        pack_en = 1;
        idle(1);
        send_word(32'hDEADBEEF);
        idle(1);
        chk("t5_level", fifo_level, 3'd1);
        chk("t5_data", word_data, 32'hDEADBEEF);
        drain();

        // reset mid-word with FIFO content
        send_word(32'h0BAD_0001);
        send_word(32'h0BAD_0002);
        for (int i = 0; i < 17; i++) send_bit(1'($urandom_range(0, 1)), 0);
        rstn = 0;
        tick();
        rstn = 1;
        chk("t6_vld", word_vld, 1'b0);
        chk("t6_level", fifo_level, 3'd0);
        chk("t6_cnt", drop_cnt, '0);
        idle(1);
        rw = $urandom;
        send_word(rw);
        idle(1);
        chk("t6_data", word_data, rw);
        drain();

        // drop counter saturation
        for (int i = 0; i < 17; i++) send_word_err(32'($urandom), 99);
        idle(1);
        chk("sat_cnt", drop_cnt, 4'hF);

        // randomised traffic
        rstn = 0;
        tick();
        rstn = 1;
        for (int c = 0; c < 2500; c++) begin
            rstn           = ($urandom_range(0, 599) != 0);
            pack_en        = ($urandom_range(0, 79) != 0);
            if ($urandom_range(0, 149) == 0) vn_en = ~vn_en;
            digi_data_vld  = ($urandom_range(0, 3) != 0);
            digi_data_out  = 1'($urandom_range(0, 1));
            healthtest_err = ($urandom_range(0, 199) == 0);
            word_rdy       = ($urandom_range(0, 2) != 0);
            tick();
        end
        rstn = 1;
        idle(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
